// File: rtl/fb_draw_engine_pkg.sv
// Shared types, default geometry and address helper for the framebuffer draw engine.
package fb_draw_pkg;

  localparam int DEF_H_RES   = 320;
  localparam int DEF_V_RES   = 240;
  localparam int DEF_ADDR_W  = 17;
  localparam int DEF_COLOR_W = 3;

  typedef enum logic [1:0] {
    OP_FILL  = 2'b00,
    OP_CLEAR = 2'b01,
    OP_FLUSH = 2'b10,
    OP_NOP   = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // 320 = 256 + 64, so the common resolution needs only two shifts and an add.
  function automatic logic [31:0] xy_to_addr(input logic [31:0] x, input logic [31:0] y,
                                             input int h_res);
    if (h_res == 320) return (y << 8) + (y << 6) + x;
    else return (y * 32'(h_res)) + x;
  endfunction

endpackage

// File: rtl/fb_draw_engine_if.sv
// Command port (from CPU/sequencer) and back-buffer write port (to video controller).
interface fb_draw_engine_if
  import fb_draw_pkg::*;
#(
  parameter int H_RES   = DEF_H_RES,
  parameter int V_RES   = DEF_V_RES,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int COLOR_W = DEF_COLOR_W
);
  localparam int X_W = $clog2(H_RES);
  localparam int Y_W = $clog2(V_RES);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [X_W-1:0]     x0;
  logic [X_W-1:0]     x1;
  logic [Y_W-1:0]     y0;
  logic [Y_W-1:0]     y1;
  logic [COLOR_W-1:0] color;
  logic [COLOR_W-1:0] wdata;
  logic [ADDR_W-1:0]  waddr;
  logic               we;
  logic               flush;
  logic               done;

  modport master (
    input  cmd_valid, cmd_op, x0, x1, y0, y1, color,
    output cmd_ready, wdata, waddr, we, flush, done
  );

  modport slave (
    output cmd_valid, cmd_op, x0, x1, y0, y1, color,
    input  cmd_ready, wdata, waddr, we, flush, done
  );

endinterface

// File: rtl/fb_draw_engine_raster_counter.sv
// Raster walker: steps x fastest, then y, keeping a row base so addresses need only adds.
module fb_raster_counter #(
  parameter int H_RES  = 320,
  parameter int X_W    = 9,
  parameter int Y_W    = 8,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [X_W-1:0]    x0,
  input  logic [X_W-1:0]    x1,
  input  logic [Y_W-1:0]    y0,
  input  logic [Y_W-1:0]    y1,
  input  logic [ADDR_W-1:0] base0,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [X_W-1:0]    x_q, x_d, x0_q, x0_d, x1_q, x1_d;
  logic [Y_W-1:0]    y_q, y_d, y1_q, y1_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    x0_d   = x0_q;
    x1_d   = x1_q;
    y1_d   = y1_q;
    base_d = base_q;
    addr_d = addr_q;
    if (load) begin
      x_d    = x0;
      y_d    = y0;
      x0_d   = x0;
      x1_d   = x1;
      y1_d   = y1;
      base_d = base0;
      addr_d = base0 + ADDR_W'(x0);
    end else if (step) begin
      if (x_q == x1_q) begin
        x_d    = x0_q;
        y_d    = y_q + Y_W'(1);
        base_d = base_q + ADDR_W'(H_RES);
        addr_d = base_q + ADDR_W'(H_RES) + ADDR_W'(x0_q);
      end else begin
        x_d    = x_q + X_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      x0_q   <= '0;
      x1_q   <= '0;
      y1_q   <= '0;
      base_q <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      x0_q   <= x0_d;
      x1_q   <= x1_d;
      y1_q   <= y1_d;
      base_q <= base_d;
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  assign last = (x_q == x1_q) && (y_q == y1_q);

endmodule

// File: rtl/fb_draw_engine.sv
// Command-driven framebuffer writer: rectangle fill / clear / flush into a
// one-pixel-per-cycle back-buffer write stream.
module fb_draw_engine
  import fb_draw_pkg::*;
#(
  parameter int H_RES   = DEF_H_RES,
  parameter int V_RES   = DEF_V_RES,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int COLOR_W = DEF_COLOR_W
) (
  input logic              i_clk,
  input logic              i_reset_n,
  fb_draw_engine_if.master bus
);

  localparam int X_W = $clog2(H_RES);
  localparam int Y_W = $clog2(V_RES);
  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic               we_q, we_d;
  logic               flush_q, flush_d;
  logic               done_q, done_d;
  logic [COLOR_W-1:0] wdata_q, wdata_d;

  cmd_op_e           op;
  logic [X_W-1:0]    x0_c, x1_c;
  logic [Y_W-1:0]    y0_c, y1_c;
  logic [ADDR_W-1:0] base0, waddr;
  logic              empty, load, step, last;

  assign op = cmd_op_e'(bus.cmd_op);

  // CLEAR reuses the FILL path with the full-screen rectangle.
  always_comb begin
    x0_c = bus.x0;
    y0_c = bus.y0;
    x1_c = (bus.x1 > X_MAX) ? X_MAX : bus.x1;
    y1_c = (bus.y1 > Y_MAX) ? Y_MAX : bus.y1;
    if (op == OP_CLEAR) begin
      x0_c = '0;
      y0_c = '0;
      x1_c = X_MAX;
      y1_c = Y_MAX;
    end
    empty = (x0_c > x1_c) || (y0_c > y1_c) ||
            (32'(x0_c) >= 32'(H_RES)) || (32'(y0_c) >= 32'(V_RES));
    base0 = ADDR_W'(xy_to_addr(32'd0, 32'(y0_c), H_RES));
  end

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    flush_d = 1'b0;
    done_d  = 1'b0;
    wdata_d = wdata_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          unique case (op)
            OP_FILL, OP_CLEAR: begin
              wdata_d = bus.color;
              if (empty) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_DRAW;
                we_d    = 1'b1;
                load    = 1'b1;
              end
            end
            OP_FLUSH: begin
              state_d = ST_FLUSH;
              flush_d = 1'b1;
            end
            default: begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      ST_DRAW: begin
        if (last) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          we_d = 1'b1;
          step = 1'b1;
        end
      end
      ST_FLUSH: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Ready resets low and rises on the first clock after reset release.
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      flush_q <= flush_d;
      done_q  <= done_d;
      wdata_q <= wdata_d;
    end
  end

  fb_raster_counter #(
    .H_RES (H_RES),
    .X_W   (X_W),
    .Y_W   (Y_W),
    .ADDR_W(ADDR_W)
  ) u_raster (
    .clk  (i_clk),
    .rst_n(i_reset_n),
    .load (load),
    .step (step),
    .x0   (x0_c),
    .x1   (x1_c),
    .y0   (y0_c),
    .y1   (y1_c),
    .base0(base0),
    .addr (waddr),
    .last (last)
  );

  assign bus.cmd_ready = ready_q;
  assign bus.we        = we_q;
  assign bus.flush     = flush_q;
  assign bus.done      = done_q;
  assign bus.wdata     = wdata_q;
  assign bus.waddr     = waddr;

endmodule
